seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector; next generation of the fixed 1001 Mealy detector.

---
 rtl/seq_det_pkg.sv | 71 +++++++
 rtl/seq_detector_param_sat_counter.sv | 36 +++
 rtl/seq_detector_param.sv | 102 ++++++++++
 tb/tb_seq_detector_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   MAX_PAT_LEN     : longest supported pattern.
//   seq_det_state_t : wide enough to hold any prefix length 0..MAX_PAT_LEN.
//   seq_det_fail    : KMP failure value (longest proper border of a pattern prefix).
//   seq_det_next    : full transition (state, bit) -> state, evaluated at elaboration.
// Bit ordering: prefix bit t of a LEN-bit pattern is pattern[len-1-t] (MSB received first).
package seq_det_pkg;

    localparam int MAX_PAT_LEN = 16;

    typedef logic [$clog2(MAX_PAT_LEN+1)-1:0] seq_det_state_t;

    // Longest j<k such that the first j pattern bits equal the last j bits of
    // the first k pattern bits.
    function automatic seq_det_state_t seq_det_fail(
        input logic [MAX_PAT_LEN-1:0] pattern,
        input int                     len,
        input int                     k
    );
        seq_det_state_t res;
        bit             found;
        bit             ok;
        res   = '0;
        found = 1'b0;
        for (int j = k - 1; j >= 1; j--) begin
            if (!found) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    if (pattern[len-1-t] != pattern[len-1-(k-j+t)]) ok = 1'b0;
                end
                if (ok) begin
                    res   = seq_det_state_t'(j);
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Walk the failure chain until the incoming bit extends a prefix.
    // A completed pattern returns F(len), i.e. the overlapping restart point.
    function automatic seq_det_state_t seq_det_next(
        input logic [MAX_PAT_LEN-1:0] pattern,
        input int                     len,
        input int                     k,
        input logic                   b
    );
        seq_det_state_t res;
        bit             done;
        int             j;
        res  = '0;
        done = 1'b0;
        j    = k;
        for (int it = 0; it <= MAX_PAT_LEN; it++) begin
            if (!done) begin
                if (b == pattern[len-1-j]) begin
                    if (j + 1 == len) res = seq_det_fail(pattern, len, len);
                    else              res = seq_det_state_t'(j + 1);
                    done = 1'b1;
                end else if (j == 0) begin
                    res  = '0;
                    done = 1'b1;
                end else begin
                    j = int'(seq_det_fail(pattern, len, j));
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock          rst : synchronous active-high reset
//   clr : clear (wins over inc)
//   inc : count request  cnt : current count, sticks at all-ones
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector (KMP automaton).
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : qualifies in; when low nothing advances
//   in         : serial data bit
//   clr_cnt    : synchronous clear of match_cnt (beats a coincident match)
//   match      : pattern-complete pulse (Mealy or registered Moore)
//   match_cnt  : saturating count of match events
//   state_dbg  : number of pattern prefix bits currently matched
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MOORE   = 1'b0,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in,
    input  logic                       clr_cnt,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(PAT_LEN)-1:0] state_dbg
);

    localparam int                        SW      = $clog2(PAT_LEN);
    localparam int                        TAB_N   = 2 ** SW;
    localparam logic [SW-1:0]             LAST    = SW'(PAT_LEN - 1);
    localparam logic [MAX_PAT_LEN-1:0]    PAT_EXT = MAX_PAT_LEN'(PATTERN);

    if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
        $error("seq_detector_param: PAT_LEN must be in 2..16");
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          match_evt;

    // Transition tables for bit 0 and bit 1, one entry per state, fixed at
    // elaboration. Unreachable encodings (PAT_LEN not a power of two) go to 0.
    logic [SW-1:0] nxt0_tab [TAB_N];
    logic [SW-1:0] nxt1_tab [TAB_N];

    for (genvar gi = 0; gi < TAB_N; gi++) begin : g_tab
        if (gi < PAT_LEN) begin : g_live
            localparam seq_det_state_t N0 = seq_det_next(PAT_EXT, PAT_LEN, gi, 1'b0);
            localparam seq_det_state_t N1 = seq_det_next(PAT_EXT, PAT_LEN, gi, 1'b1);
            assign nxt0_tab[gi] = SW'(N0);
            assign nxt1_tab[gi] = SW'(N1);
        end else begin : g_pad
            assign nxt0_tab[gi] = '0;
            assign nxt1_tab[gi] = '0;
        end
    end

    assign match_evt = in_valid && (state_q == LAST) && (in == PATTERN[0]);

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            // Full-match entries already hold F(PAT_LEN); only the
            // non-overlapping variant needs to restart from empty.
            if (match_evt && !OVERLAP) state_d = '0;
            else if (in)               state_d = nxt1_tab[state_q];
            else                       state_d = nxt0_tab[state_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= '0;
        else     state_q <= state_d;
    end

    assign state_dbg = state_q;

    if (MOORE) begin : g_moore
        logic match_q;
        logic match_d;
        // One-cycle pulse on the cycle after the final bit is accepted.
        always_comb match_d = match_evt;
        always_ff @(posedge clk) begin
            if (rst) match_q <= 1'b0;
            else     match_q <= match_d;
        end
        assign match = match_q;
    end else begin : g_mealy
        assign match = match_evt;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (match_evt),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: five parameterisations share one stimulus
// stream (the Moore instance sees every bit as valid). A history-based model
// predicts match / match_cnt / state_dbg for every instance each cycle, and
// directed sequences pin literal expectations.
module tb_seq_detector_param;

    localparam int NI = 5;
    localparam int               LEN  [NI] = '{4, 4, 4, 5, 4};
    localparam logic [15:0]      PAT  [NI] = '{16'h0009, 16'h0009, 16'h0009, 16'h001B, 16'h0009};
    localparam bit               OVL  [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam bit               MOO  [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam int               CMAX [NI] = '{255, 255, 255, 255, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv  = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;

    logic       m0, m1, m2, m3, m4;
    logic [7:0] c0, c1, c2, c3;
    logic [1:0] c4;
    logic [1:0] s0, s1, s2, s4;
    logic [2:0] s3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_detector_param u0 (
        .clk(clk), .rst(rst), .in_valid(iv), .in(din), .clr_cnt(clr),
        .match(m0), .match_cnt(c0), .state_dbg(s0));

    seq_detector_param #(.OVERLAP(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv), .in(din), .clr_cnt(clr),
        .match(m1), .match_cnt(c1), .state_dbg(s1));

    seq_detector_param #(.MOORE(1'b1)) u2 (
        .clk(clk), .rst(rst), .in_valid(1'b1), .in(din), .clr_cnt(clr),
        .match(m2), .match_cnt(c2), .state_dbg(s2));

    seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b11011)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv), .in(din), .clr_cnt(clr),
        .match(m3), .match_cnt(c3), .state_dbg(s3));

    seq_detector_param #(.CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv), .in(din), .clr_cnt(clr),
        .match(m4), .match_cnt(c4), .state_dbg(s4));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // hist: accepted bits, newest in bit 0. nacc: bits accepted since reset
    // (or since the last match when overlap is off).
    bit [63:0] hist [NI];
    int        nacc [NI];
    int        mcnt [NI];
    bit        mreg [NI];
    bit        model_on = 1'b0;

    function automatic bit inst_valid(int i, bit v);
        return (i == 2) ? 1'b1 : v;
    endfunction

    function automatic bit ev_now(int i, bit v, bit b);
        bit [63:0] h;
        bit [15:0] mask;
        if (!inst_valid(i, v)) return 1'b0;
        h    = {hist[i][62:0], b};
        mask = 16'((32'd1 << LEN[i]) - 1);
        return (nacc[i] + 1 >= LEN[i]) && ((h[15:0] & mask) == (PAT[i] & mask));
    endfunction

    function automatic int st_now(int i);
        bit ok;
        for (int j = LEN[i] - 1; j > 0; j--) begin
            if (j <= nacc[i]) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++)
                    if (hist[i][j-1-t] != PAT[i][LEN[i]-1-t]) ok = 1'b0;
                if (ok) return j;
            end
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        bit e;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                hist[i] = '0; nacc[i] = 0; mcnt[i] = 0; mreg[i] = 1'b0;
            end else begin
                e = ev_now(i, iv, din);
                if (clr)                        mcnt[i] = 0;
                else if (e && mcnt[i] < CMAX[i]) mcnt[i]++;
                mreg[i] = e;
                if (inst_valid(i, iv)) begin
                    hist[i] = {hist[i][62:0], din};
                    if (e && !OVL[i])       nacc[i] = 0;
                    else if (nacc[i] < 1000) nacc[i]++;
                end
            end
        end
        if (rst) model_on = 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int am [NI];
        int ac [NI];
        int as [NI];
        int em;
        am = '{int'(m0), int'(m1), int'(m2), int'(m3), int'(m4)};
        ac = '{int'(c0), int'(c1), int'(c2), int'(c3), int'(c4)};
        as = '{int'(s0), int'(s1), int'(s2), int'(s3), int'(s4)};
        if (model_on) begin
            for (int i = 0; i < NI; i++) begin
                em = MOO[i] ? int'(mreg[i]) : int'(ev_now(i, iv, din));
                chk($sformatf("model_match_u%0d", i), am[i], em);
                chk($sformatf("model_cnt_u%0d", i),   ac[i], mcnt[i]);
                chk($sformatf("model_state_u%0d", i), as[i], st_now(i));
            end
        end
    end

    // ---------------- stimulus ----------------
    bit verbose = 1'b1;

    task automatic step(input bit v, input bit b, input bit c, input bit r);
        @(posedge clk);
        #1;
        iv = v; din = b; clr = c; rst = r;
        @(negedge clk);
        if (verbose)
            $display("t=%0t rst=%0d v=%0d in=%0d clr=%0d | u0 m=%0d cnt=%0d st=%0d | u3 m=%0d st=%0d",
                     $time, r, v, b, c, m0, c0, s0, m3, s3);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit [6:0] s1001, e_u0, e_u1, e_u2, v5, b5, e5;
        bit [7:0] s4, e_u3;

        // Reset state
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_u0_cnt", c0, 0);
        chk("rst_u0_state", s0, 0);
        chk("rst_u0_match", m0, 0);
        chk("rst_u2_match", m2, 0);
        chk("rst_u4_cnt", c4, 0);

        // Stream 1001001: overlap, non-overlap, Moore
        s1001 = 7'b1001001;
        e_u0  = 7'b0001001;
        e_u1  = 7'b0001000;
        e_u2  = 7'b0000100;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, s1001[6-k], 1'b0, 1'b0);
            chk("t1_u0_match", m0, e_u0[6-k]);
            chk("t2_u1_match", m1, e_u1[6-k]);
            chk("t3_u2_match", m2, e_u2[6-k]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_u2_match_late", m2, 1);
        chk("t1_u0_cnt", c0, 2);
        chk("t2_u1_cnt", c1, 1);
        chk("t3_u2_cnt", c2, 2);

        // 11011 pattern, overlapping matches on bits 5 and 8
        do_reset();
        s4   = 8'b11011011;
        e_u3 = 8'b00001001;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, s4[7-k], 1'b0, 1'b0);
            chk("t4_u3_match", m3, e_u3[7-k]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_u3_cnt", c3, 2);
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_u3_state_111", s3, 2);

        // in_valid gaps: 1,0, gap x3 with toggling in, then 0,1
        do_reset();
        v5 = 7'b1100011;
        b5 = 7'b1010101;
        e5 = 7'b0000001;
        for (int k = 0; k < 7; k++) begin
            step(v5[6-k], b5[6-k], 1'b0, 1'b0);
            chk("t5_u0_match", m0, e5[6-k]);
            if (!v5[6-k]) chk("t5_u0_state_gap", s0, 2);
        end

        // CNT_W=2 saturation, clear priority, reset mid-pattern
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_u4_cnt_sat", c4, 3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_u4_match_with_clr", m4, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_u4_cnt_clr_wins", c4, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_u0_no_match_after_rst", m0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_u0_state_after_rst", s0, 1);

        // Randomised traffic, checked by the model every cycle
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 75,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
